// File: rtl/ram_wsync.sv
// ram_wsync: byte-addressed big-endian RAM with a fixed wait-state count and
// a four-phase Enable/MOC handshake; misaligned or reserved-size requests complete with Error.
module ram_wsync #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Enable,
    input  logic                  ReadWrite,
    input  logic [1:0]            Size,
    input  logic                  Signed,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MOC,
    output logic                  Busy,
    output logic                  Error
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [3:0] LAST = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic commit, rw_q, sg_q, rw, sg, bad;
    logic [1:0] sz_q, sz;
    logic [ADDR_WIDTH-1:0] a_q, a;
    logic [31:0] d_q, d, rd;
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] mem [2**ADDR_WIDTH];
    // With zero wait states the access commits on the accepting edge, so it must use the live inputs.
    assign rw  = state == IDLE ? ReadWrite : rw_q;
    assign sg  = state == IDLE ? Signed : sg_q;
    assign sz  = state == IDLE ? Size : sz_q;
    assign a   = state == IDLE ? Address : a_q;
    assign d   = state == IDLE ? DataIn : d_q;
    assign bad = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    assign r0  = mem[a];
    assign r1  = mem[a | ADDR_WIDTH'(1)];
    assign r2  = mem[a | ADDR_WIDTH'(2)];
    assign r3  = mem[a | ADDR_WIDTH'(3)];
    assign rd  = sz == 2'b10 ? {r0, r1, r2, r3} :
                 sz == 2'b01 ? {{16{sg && r0[7]}}, r0, r1} : {{24{sg && r0[7]}}, r0};
    assign MOC  = state == DONE;
    assign Busy = state != IDLE;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: if (Enable) begin
                state_nx = WAIT_STATES == 0 ? DONE : WAIT;
                commit   = WAIT_STATES == 0;
                cnt_nx   = '0;
            end
            WAIT: begin
                state_nx = cnt == LAST ? DONE : WAIT;
                commit   = cnt == LAST;
                cnt_nx   = cnt == LAST ? cnt : cnt + 4'd1;
            end
            DONE: state_nx = Enable ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            sg_q    <= 1'b0;
            sz_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            DataOut <= '0;
            Error   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && Enable) begin
                rw_q <= ReadWrite;
                sg_q <= Signed;
                sz_q <= Size;
                a_q  <= Address;
                d_q  <= DataIn;
            end
            Error <= commit ? bad : (state_nx == IDLE ? 1'b0 : Error);
            if (commit && rw && !bad) DataOut <= rd;
        end
    end
    // Memory has no reset; gating on Reset_n keeps a zero-wait request from committing during reset.
    always_ff @(posedge Clk) begin
        if (Reset_n && commit && !rw && !bad) begin
            if (sz == 2'b10) begin
                mem[a]                  <= d[31:24];
                mem[a | ADDR_WIDTH'(1)] <= d[23:16];
                mem[a | ADDR_WIDTH'(2)] <= d[15:8];
                mem[a | ADDR_WIDTH'(3)] <= d[7:0];
            end else if (sz == 2'b01) begin
                mem[a]                  <= d[15:8];
                mem[a | ADDR_WIDTH'(1)] <= d[7:0];
            end else begin
                mem[a] <= d[7:0];
            end
        end
    end
endmodule

// File: tb/tb_ram_wsync.sv
// tb_ram_wsync: random and directed stimulus for ram_wsync, checked every cycle against a
// transaction-level model, plus a zero-wait instance checked with literal expectations.
module tb_ram_wsync;
    localparam int WS = 2;
    logic Clk = 0, Reset_n = 0;
    logic Enable = 0, ReadWrite = 0, Signed = 0;
    logic [1:0] Size = 0;
    logic [8:0] Address = 0;
    logic [31:0] DataIn = 0, DataOut;
    logic MOC, Busy, Error;
    logic en0 = 0, rw0 = 0, sg0 = 0;
    logic [1:0] sz0 = 0;
    logic [8:0] ad0 = 0;
    logic [31:0] di0 = 0, do0;
    logic moc0, busy0, err0;
    int checks = 0, errs = 0;

    ram_wsync #(.ADDR_WIDTH(9), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .ReadWrite(ReadWrite), .Size(Size),
        .Signed(Signed), .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC),
        .Busy(Busy), .Error(Error));
    ram_wsync #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(en0), .ReadWrite(rw0), .Size(sz0),
        .Signed(sg0), .Address(ad0), .DataIn(di0), .DataOut(do0), .MOC(moc0),
        .Busy(busy0), .Error(err0));

    always #5 Clk = ~Clk;

    // Transaction model: edges since acceptance, memory as a byte array.
    logic [7:0] mm [512];
    logic m_busy = 0, m_moc = 0, m_err = 0;
    logic [31:0] m_do = 0;
    int m_n = 0;
    logic q_rw, q_sg;
    logic [1:0] q_sz;
    logic [8:0] q_a;
    logic [31:0] q_d;

    task automatic commit(input logic rw, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                          input logic [31:0] d);
        int nb;
        logic bad;
        logic [63:0] v;
        bad = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
        nb = 1 << sz;
        m_moc <= 1;
        m_err <= bad;
        if (!bad && !rw)
            for (int i = 0; i < nb; i++) mm[int'(a) + i] <= d[8*(nb-1-i) +: 8];
        if (!bad && rw) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mm[int'(a) + i]);
            if (sg && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
            m_do <= v[31:0];
        end
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_busy <= 0; m_moc <= 0; m_err <= 0; m_do <= 0; m_n <= 0;
        end else if (!m_busy) begin
            if (Enable) begin
                q_rw <= ReadWrite; q_sz <= Size; q_sg <= Signed; q_a <= Address; q_d <= DataIn;
                m_busy <= 1; m_n <= 1;
                if (WS == 0) commit(ReadWrite, Size, Signed, Address, DataIn);
            end
        end else if (!m_moc) begin
            m_n <= m_n + 1;
            if (m_n + 1 == WS + 1) commit(q_rw, q_sz, q_sg, q_a, q_d);
        end else if (!Enable) begin
            m_busy <= 0; m_moc <= 0; m_err <= 0;
        end
    end

    always @(negedge Clk) begin
        checks++;
        if (Busy !== m_busy || MOC !== m_moc || Error !== m_err || DataOut !== m_do) begin
            errs++;
            $display("FAIL cycle t=%0t got busy=%b moc=%b err=%b do=%h want busy=%b moc=%b err=%b do=%h",
                     $time, Busy, MOC, Error, DataOut, m_busy, m_moc, m_err, m_do);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic req(input logic rw, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                       input logic [31:0] d, input int hold, output int lat,
                       output logic [31:0] dv, output logic ev);
        @(negedge Clk); #1;
        ReadWrite = rw; Size = sz; Signed = sg; Address = a; DataIn = d; Enable = 1;
        lat = 0;
        do begin
            @(posedge Clk); lat++; #1;
            ReadWrite = 1'($urandom); Size = 2'($urandom); Signed = 1'($urandom);
            Address = 9'($urandom); DataIn = $urandom;
        end while (!MOC && lat < 40);
        if (!MOC) check("moc_timeout", 32'(MOC), 1);
        dv = DataOut; ev = Error;
        repeat (hold) @(posedge Clk);
        @(negedge Clk); #1 Enable = 0;
        @(posedge Clk); #1;
        check("moc_drop", 32'(MOC), 0);
        check("busy_drop", 32'(Busy), 0);
    endtask

    task automatic req0(input logic rw, input logic [1:0] sz, input logic [8:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] dv);
        @(negedge Clk); #1;
        rw0 = rw; sz0 = sz; sg0 = 0; ad0 = a; di0 = d; en0 = 1;
        lat = 0;
        do begin
            @(posedge Clk); lat++; #1;
            ad0 = 9'($urandom); di0 = $urandom;
        end while (!moc0 && lat < 40);
        check("moc0", 32'(moc0), 1);
        check("err0", 32'(err0), 0);
        dv = do0;
        @(negedge Clk); #1 en0 = 0;
        @(posedge Clk); #1;
        check("moc0_drop", 32'(moc0), 0);
    endtask

    initial begin
        int lat;
        logic [31:0] dv;
        logic ev;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_do", DataOut, 0);
        check("rst_busy", 32'(Busy), 0);
        @(negedge Clk); Reset_n = 1;
        for (int i = 0; i < 128; i++) req(0, 2, 0, 9'(i * 4), $urandom, 0, lat, dv, ev);
        req(0, 2, 0, 8, 32'hAE910F2B, 0, lat, dv, ev);
        check("wr_lat", 32'(lat), 3);
        req(1, 2, 0, 8, 0, 0, lat, dv, ev);
        check("rd_lat", 32'(lat), 3);
        check("rd_word8", dv, 32'hAE910F2B);
        req(1, 0, 1, 8, 0, 0, lat, dv, ev);
        check("rdb8_s", dv, 32'hFFFFFFAE);
        req(1, 0, 0, 8, 0, 0, lat, dv, ev);
        check("rdb8_u", dv, 32'h000000AE);
        req(1, 0, 0, 9, 0, 0, lat, dv, ev);
        check("rdb9", dv, 32'h00000091);
        req(1, 0, 1, 11, 0, 0, lat, dv, ev);
        check("rdb11", dv, 32'h0000002B);
        req(1, 1, 1, 10, 0, 0, lat, dv, ev);
        check("rdh10_s", dv, 32'h00000F2B);
        req(1, 2, 0, 8, 0, 0, lat, dv, ev);
        req(0, 2, 0, 2, 32'h12345678, 0, lat, dv, ev);
        check("mis_wr_err", 32'(ev), 1);
        check("mis_wr_do", dv, 32'hAE910F2B);
        req(1, 1, 0, 5, 0, 0, lat, dv, ev);
        check("mis_rd_err", 32'(ev), 1);
        check("mis_rd_do", dv, 32'hAE910F2B);
        req(1, 3, 0, 8, 0, 0, lat, dv, ev);
        check("sz3_err", 32'(ev), 1);
        req(1, 2, 0, 0, 0, 0, lat, dv, ev);
        check("ok_err", 32'(ev), 0);
        req(1, 0, 0, 9, 0, 10, lat, dv, ev);
        check("hs_do", dv, 32'h00000091);
        req(1, 1, 0, 8, 0, 0, lat, dv, ev);
        check("hs_next_lat", 32'(lat), 3);
        check("hs_next_do", dv, 32'h0000AE91);
        req(0, 0, 0, 0, 32'h11, 0, lat, dv, ev);
        @(negedge Clk); #1;
        ReadWrite = 0; Size = 0; Signed = 0; Address = 0; DataIn = 32'hAB; Enable = 1;
        @(posedge Clk); #2 Reset_n = 0;
        #1;
        check("rstw_moc", 32'(MOC), 0);
        check("rstw_busy", 32'(Busy), 0);
        check("rstw_do", DataOut, 0);
        Enable = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk); Reset_n = 1;
        req(1, 0, 0, 0, 0, 0, lat, dv, ev);
        check("rstw_mem0", dv, 32'h00000011);
        for (int i = 0; i < 300; i++) begin
            req(1'($urandom), 2'($urandom), 1'($urandom), 9'($urandom), $urandom,
                int'($urandom_range(0, 3)), lat, dv, ev);
            check("rnd_lat", 32'(lat), 3);
        end
        req0(0, 2, 0, 32'hDEADBEEF, lat, dv);
        req0(0, 2, 508, 32'h01234567, lat, dv);
        check("z_lat", 32'(lat), 1);
        req0(1, 0, 508, 0, lat, dv);
        check("z_b508", dv, 32'h00000001);
        req0(1, 0, 511, 0, lat, dv);
        check("z_b511", dv, 32'h00000067);
        req0(1, 2, 508, 0, lat, dv);
        check("z_w508", dv, 32'h01234567);
        req0(1, 2, 0, 0, lat, dv);
        check("z_nowrap", dv, 32'hDEADBEEF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule

// File: doc/ram_wsync.md
RAM_WSYNC -- requirements
Module: ram_wsync

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, byte-address width; memory depth is 2**ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, number of wait cycles (0..15) inserted before each access completes.
REQ-003 The block SHALL have the following ports, in this order:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  active-low reset
- Enable  input  1  request strobe, level-held until MOC
- ReadWrite  input  1  1 = read, 0 = write
- Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved
- Signed  input  1  1 = sign-extend byte/halfword reads, 0 = zero-extend
- Address  input  ADDR_WIDTH  byte address
- DataIn  input  32  write data, right-justified
- DataOut  output  32  read data, right-justified
- MOC  output  1  memory operation complete
- Busy  output  1  request accepted and not yet completed
- Error  output  1  completed request was rejected
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset (Reset_n); all state SHALL change only on the rising edge of Clk or on assertion of Reset_n.

Function
REQ-005 The block SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-006 In IDLE, a rising Clk edge with Enable=1 SHALL latch ReadWrite, Size, Signed, Address and DataIn, and SHALL go to WAIT (WAIT_STATES>0) or DONE (WAIT_STATES=0).
REQ-007 Inputs that change after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-008 WAIT SHALL count WAIT_STATES cycles and then go to DONE; the memory access SHALL occur on the edge that enters DONE.
REQ-009 MOC SHALL assert exactly WAIT_STATES+1 edges after the accepting edge and SHALL stay high while in DONE.
REQ-010 In DONE, Enable=0 at a rising edge SHALL return the FSM to IDLE with MOC=0 (four-phase handshake); while Enable remains 1, the FSM SHALL stay in DONE and no new request SHALL be accepted.
REQ-011 Busy SHALL be 1 in WAIT and DONE, and 0 in IDLE.
REQ-012 Byte ordering SHALL be big-endian: a word at address A SHALL map DataIn[31:24] to A, [23:16] to A+1, [15:8] to A+2 and [7:0] to A+3; a halfword SHALL map [15:8] to A and [7:0] to A+1; a byte SHALL map [7:0] to A.
REQ-013 Reads SHALL load DataOut right-justified; the upper bits SHALL be filled with the sign bit of the loaded datum when Signed=1, and with zeros otherwise.
REQ-014 A request SHALL be rejected if any of the following holds: Size=11; a halfword has Address[0]=1; a word has Address[1:0] not equal to 00.
REQ-015 A rejected request SHALL follow the normal timing and set Error=1 with MOC, SHALL NOT modify memory, and SHALL leave DataOut unchanged.
REQ-016 Error SHALL be valid only while MOC=1 and SHALL clear on leaving DONE.
REQ-017 DataOut SHALL hold its last value across writes, errors and idle cycles.
REQ-018 A write SHALL NOT alter DataOut.
REQ-019 Memory SHALL NOT have a reset value; contents SHALL persist through reset.

Reset
REQ-020 While Reset_n=0, the block SHALL force FSM=IDLE, MOC=0, Busy=0, Error=0, DataOut=32'h00000000 and wait counter=0.
REQ-021 Reset asserted in WAIT SHALL abort the request; a pending write SHALL NOT modify memory.
REQ-022 Reset asserted in DONE SHALL leave already-committed memory intact.
REQ-023 After Reset_n deasserts, the first rising edge with Enable=1 SHALL be accepted.

Verification
REQ-024 Word write then read: with WAIT_STATES=2, write 32'hAE910F2B at address 8, then read the word at 8 -> MOC rises 3 edges after acceptance; bytes 8..11 = AE,91,0F,2B; DataOut=AE910F2B.
REQ-025 Sign extension: byte read at 8 with Signed=1 -> FFFFFFAE; with Signed=0 -> 000000AE. Halfword read at 10 with Signed=1 -> 00000F2B.
REQ-026 Misalignment: word write at address 2 and halfword read at address 5 -> MOC=1 with Error=1; memory unchanged; DataOut holds its previous value.
REQ-027 Handshake: hold Enable=1 for 10 cycles after MOC -> MOC stays 1 and exactly one access occurs; after Enable drops, MOC=0 on the next edge and the next request is accepted.
REQ-028 Reset in WAIT: start a byte write of AB at address 0 (previously 11), pull Reset_n low mid-WAIT -> outputs zero immediately; Mem[0] remains 11.
REQ-029 Zero-wait / top-of-memory case: with WAIT_STATES=0, write a word at address 508 (ADDR_WIDTH=9) -> MOC on the next edge; bytes 508..511 written, no wrap-around.
